// File: rtl/aes_key_pkg.sv
// Shared types, constants and helpers for the AES-128 inverse key schedule.
package aes_key_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  // Round constants. Entry 0 is never used.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2,
    STEP = 2'd3
  } state_t;

  // Multiplication by x^-1 in GF(2^8), used to walk the rcon sequence backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? ((a >> 1) ^ 8'h8D) : (a >> 1);
  endfunction

endpackage

// File: rtl/aes_inv_g_word.sv
// g-function for the inverse step: SubWord(RotWord(w3)) ^ {rcon,24'h0}, registered.
module aes_inv_g_word
  import aes_key_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] w3,
  input  logic [7:0]        rcon,
  output logic [WORD_W-1:0] g_reg
);

  logic [WORD_W-1:0] rot_word;
  logic [WORD_W-1:0] sub_word;

  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    s_box u_s_box (
      .in_byte  (rot_word[8*i +: 8]),
      .out_byte (sub_word[8*i +: 8])
    );
  end

  // Capture the g word during SUB so the S-box path is cut from the key update.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      g_reg <= '0;
    end else if (en) begin
      g_reg <= sub_word ^ {rcon, 24'h000000};
    end
  end

endmodule

// File: rtl/s_box.sv
// AES forward S-box computed as GF(2^8) inverse followed by the affine map.
module s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  logic [7:0] b;

  // Inverse then affine transform: b ^ rotl1..rotl4 ^ 0x63.
  always_comb begin
    b        = gf_inv(in_byte);
    out_byte = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_expand.sv
// AES-128 inverse key schedule: streams round keys NUM_ROUNDS..0 over valid/ready.
module aes_inv_key_expand
  import aes_key_pkg::*;
#(
  parameter int NUM_ROUNDS = 10  // legal range 1..10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             ready_in,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             done
);

  state_t            state_q;
  state_t            state_d;
  logic [KEY_W-1:0]  key_reg;
  logic [7:0]        rcon_reg;
  logic [3:0]        idx_q;
  logic              done_q;
  logic [WORD_W-1:0] g_reg;
  logic              handshake;

  logic [WORD_W-1:0] w4, w5, w6, w7;
  logic [WORD_W-1:0] w1, w2, w3;

  assign {w4, w5, w6, w7} = key_reg;
  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;

  assign handshake = (state_q == EMIT) && key_ready;
  assign round_key = key_reg;
  assign round_idx = idx_q;
  assign done      = done_q;

  aes_inv_g_word u_g_word (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == SUB),
    .w3    (w3),
    .rcon  (rcon_reg),
    .g_reg (g_reg)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    ready_in  = 1'b0;
    key_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready_in = 1'b1;
        if (start) state_d = EMIT;
      end
      EMIT: begin
        key_valid = 1'b1;
        if (key_ready) state_d = (idx_q == 4'd0) ? IDLE : SUB;
      end
      SUB:     state_d = STEP;
      STEP:    state_d = EMIT;
      default: state_d = IDLE;
    endcase
  end

  // Key, rcon and index registers; STEP is only reached with idx_q > 0, so no wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_reg  <= '0;
      rcon_reg <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            key_reg  <= key_in;
            rcon_reg <= RCON[NUM_ROUNDS];
            idx_q    <= 4'(NUM_ROUNDS);
          end
        end
        STEP: begin
          key_reg  <= {w4 ^ g_reg, w1, w2, w3};
          rcon_reg <= inv_xtime(rcon_reg);
          idx_q    <= idx_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // One-cycle done pulse after round 0 is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= handshake && (idx_q == 4'd0);
  end

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Scoreboard bench for aes_inv_key_expand using FIPS-197 A.1 round keys.
module tb_aes_inv_key_expand;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  // FIPS-197 A.1 expansion of 2b7e151628aed2a6abf7158809cf4f3c, rounds 0..10.
  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  // rcon that must be held while round key idx is presented (idx 1..10).
  logic [7:0] rcon_exp [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  localparam logic [127:0] JUNK_KEY = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start1;
  logic [127:0] key_in, key_in1;
  logic         key_ready, key_ready1;
  logic         ready_in, ready_in1;
  logic [127:0] round_key, round_key1;
  logic [3:0]   round_idx, round_idx1;
  logic         key_valid, key_valid1;
  logic         done, done1;

  int checks = 0;
  int errors = 0;
  exp_t exp_q  [$];
  exp_t exp1_q [$];

  always #5 clk = ~clk;

  aes_inv_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .ready_in  (ready_in),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .done      (done)
  );

  aes_inv_key_expand #(.NUM_ROUNDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .key_in    (key_in1),
    .ready_in  (ready_in1),
    .round_key (round_key1),
    .round_idx (round_idx1),
    .key_valid (key_valid1),
    .key_ready (key_ready1),
    .done      (done1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 10-round instance: compare every accepted key.
  always @(negedge clk) begin
    exp_t e;
    if (key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key", 128'(round_idx), 128'hF);
      end else begin
        e = exp_q.pop_front();
        check("round_idx", 128'(round_idx), 128'(e.idx));
        check("round_key", round_key, e.key);
        if (e.idx != 4'd0) check("rcon_reg", 128'(dut.rcon_reg), 128'(rcon_exp[e.idx]));
      end
    end
  end

  // Monitor for the 1-round instance.
  always @(negedge clk) begin
    exp_t e;
    if (key_valid1 && key_ready1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_key1", 128'(round_idx1), 128'hF);
      end else begin
        e = exp1_q.pop_front();
        check("round_idx1", 128'(round_idx1), 128'(e.idx));
        check("round_key1", round_key1, e.key);
      end
    end
  end

  task automatic push_walk();
    for (int i = 10; i >= 0; i--) exp_q.push_back('{idx: 4'(i), key: fips[i]});
  endtask

  // One walk of the 10-round instance with optional stall, junk starts,
  // reset abort (at cycle abort_at) and a chained start in the done cycle.
  task automatic run_walk(input bit drive_start, input bit stall, input bit junk,
                          input int abort_at, input bit chain, input int exp_cycles);
    int n;
    int stall_left;
    bit stalled;
    bit seen_done;
    if (drive_start) begin
      @(posedge clk); #1;
      start  = 1'b1;
      key_in = fips[10];
    end
    push_walk();
    key_ready  = 1'b1;
    n          = 0;
    stall_left = 0;
    stalled    = 1'b0;
    seen_done  = 1'b0;
    while (!seen_done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (junk && (n == 1 || n == 2)) begin
        start  = 1'b1;
        key_in = JUNK_KEY;
        check("ready_in_busy", 128'(ready_in), 128'd0);
      end else begin
        start = 1'b0;
      end
      if (abort_at != 0 && n == abort_at) begin
        check("abort_idx", 128'(round_idx), 128'd4);
        rst = 1'b0;
        #1;
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_ready_in", 128'(ready_in), 128'd1);
        check("rst_round_key", round_key, 128'd0);
        check("rst_round_idx", 128'(round_idx), 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          check("no_done_after_rst", 128'({done, key_valid}), 128'd0);
        end
        return;
      end
      if (stall_left > 0) begin
        check("stall_idx", 128'(round_idx), 128'd7);
        check("stall_valid", 128'(key_valid), 128'd1);
        check("stall_key", round_key, fips[7]);
        stall_left--;
        if (stall_left == 0) key_ready = 1'b1;
      end else if (stall && !stalled && key_valid && round_idx == 4'd7) begin
        key_ready  = 1'b0;
        stall_left = 5;
        stalled    = 1'b1;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_latency", 128'(n), 128'(exp_cycles));
        check("done_ready_in", 128'(ready_in), 128'd1);
        check("done_round_idx", 128'(round_idx), 128'd0);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        if (chain) begin
          start  = 1'b1;
          key_in = fips[10];
        end
      end
    end
    if (!seen_done) check("done_timeout", 128'(n), 128'(exp_cycles));
    if (!chain) begin
      @(posedge clk); #1;
      check("done_one_cycle", 128'(done), 128'd0);
    end
  endtask

  task automatic run_walk1();
    int n;
    bit seen_done;
    @(posedge clk); #1;
    start1  = 1'b1;
    key_in1 = fips[1];
    exp1_q.push_back('{idx: 4'd1, key: fips[1]});
    exp1_q.push_back('{idx: 4'd0, key: fips[0]});
    key_ready1 = 1'b1;
    n = 0;
    seen_done = 1'b0;
    while (!seen_done && n < 50) begin
      @(posedge clk); #1;
      n++;
      start1 = 1'b0;
      if (done1) begin
        seen_done = 1'b1;
        check("done1_latency", 128'(n), 128'd5);
        check("queue1_drained", 128'(exp1_q.size()), 128'd0);
      end
    end
    if (!seen_done) check("done1_timeout", 128'(n), 128'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    start1     = 1'b0;
    key_in     = '0;
    key_in1    = '0;
    key_ready  = 1'b0;
    key_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_in", 128'(ready_in), 128'd1);
    check("reset_key_valid", 128'(key_valid), 128'd0);
    check("reset_round_key", round_key, 128'd0);
    check("reset_round_idx", 128'(round_idx), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_key_ready_no_effect", 128'({key_valid, ready_in}), 128'd1);

    run_walk(1'b1, 1'b0, 1'b0, 0, 1'b0, 32);  // plain FIPS walk
    run_walk(1'b1, 1'b1, 1'b0, 0, 1'b0, 37);  // 5-cycle stall on idx 7
    run_walk(1'b1, 1'b0, 1'b1, 0, 1'b1, 32);  // junk starts, then chain
    run_walk(1'b0, 1'b0, 1'b0, 0, 1'b0, 32);  // walk started in done cycle
    run_walk(1'b1, 1'b0, 1'b0, 21, 1'b0, 0);  // reset during STEP of idx 4
    run_walk(1'b1, 1'b0, 1'b0, 0, 1'b0, 32);  // full walk after reset
    run_walk1();

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 128'(exp_q.size()), 128'd0);
    check("final_queue1", 128'(exp1_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
